// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore FSM driving fetch-unit mux selects and PC strobe (LOAD x N -> FETCH -> ISSUE -> EXEC -> WB -> ADV).
// Define WATCHDOG_EN to build the EXEC/WB timeout that raises sticky ERR and halts.
module fetch_sequencer #(
  parameter int unsigned N          = 2,
  parameter int unsigned REGN       = 512,
  parameter logic [31:0] HALT_OP    = 32'hFFFF_FFFF,
  parameter int unsigned WDT_CYCLES = 255,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CW = (REGN > 1) ? $clog2(REGN) : 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  input  logic          MAT_VALID,
  input  logic          INSTR_VALID,
  input  logic [31:0]   INSTR,
  input  logic          EXEC_DONE,
  input  logic          OUT_READY,
  output logic          MATD_MUX,
  output logic          INS_MUX,
  output logic          DOUT_MUX,
  output logic          DONE,
  output logic          EXEC_START,
  output logic [IW-1:0] MAT_IDX,
  output logic [CW-1:0] INSTR_CNT,
  output logic          BUSY,
  output logic          HALTED,
  output logic          ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_ADV   = 3'd6;
  localparam logic [2:0] S_HALT  = 3'd7;

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REGN - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [IW-1:0] mat_idx;
  logic [CW-1:0] instr_cnt;
  logic          exec_first;
  logic          wdt_trip;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_LOAD;
      S_LOAD:  if (MAT_VALID && (mat_idx == IDX_LAST)) state_nxt = S_FETCH;
      S_FETCH: if (INSTR_VALID) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (INSTR == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:  if (EXEC_DONE) state_nxt = S_WB;
      S_WB:    if (OUT_READY) state_nxt = S_ADV;
      S_ADV:   state_nxt = (instr_cnt == CNT_LAST) ? S_HALT : S_LOAD;
      default: state_nxt = S_HALT;
    endcase
    // A watchdog timeout overrides any handshake completing in the same cycle
    if (wdt_trip) state_nxt = S_HALT;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      mat_idx    <= '0;
      instr_cnt  <= '0;
      exec_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      exec_first <= (state == S_ISSUE) && (state_nxt == S_EXEC);
      if ((state == S_LOAD) && MAT_VALID)
        mat_idx <= (mat_idx == IDX_LAST) ? '0 : mat_idx + 1'b1;
      if (state == S_ADV)
        instr_cnt <= (instr_cnt == CNT_LAST) ? '0 : instr_cnt + 1'b1;
    end
  end

`ifdef WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES + 1);

  logic [WW-1:0] wdt_cnt;
  logic          err;

  // Counter holds the number of EXEC/WB cycles already completed for this instruction
  assign wdt_trip = ((state == S_EXEC) || (state == S_WB)) &&
                    (wdt_cnt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wdt_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wdt_cnt <= '0;
      else if ((state == S_EXEC) || (state == S_WB))
        wdt_cnt <= wdt_cnt + 1'b1;
      if (wdt_trip)
        err <= 1'b1;
    end
  end

  assign ERR = err;
`else
  assign wdt_trip = 1'b0;
  assign ERR      = 1'b0 & (WDT_CYCLES != 0);
`endif

  assign MATD_MUX   = (state == S_LOAD);
  assign INS_MUX    = (state == S_FETCH);
  assign DOUT_MUX   = (state == S_WB);
  assign DONE       = (state == S_ADV);
  assign EXEC_START = exec_first;
  assign MAT_IDX    = mat_idx;
  assign INSTR_CNT  = instr_cnt;
  assign BUSY       = (state != S_IDLE) && (state != S_HALT);
  assign HALTED     = (state == S_HALT);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM that drives the fetch unit's mux selects (MATD_MUX, INS_MUX, DOUT_MUX) and its DONE/next-PC strobe. Per instruction it runs: load N matrix operand words, fetch instruction, issue to execute, wait for completion, hand result out, advance PC. It sits between the fetch unit, instruction/data sources, the SIMD execute stage and the result consumer, using valid/ready handshakes on each side.

Parameters:
N, 2, matrix operand words loaded per instruction (SIMD lanes), >=1
REGN, 512, instruction memory depth; sets INSTR_CNT width = clog2(REGN)
HALT_OP, 32'hFFFF_FFFF, instruction encoding that stops the sequencer
WDT_CYCLES, 255, watchdog limit in cycles (used only with watchdog macro)

Ports:
CLK  in  1  clock
RSTN  in  1  reset; one clock, reset asynchronous and active-low
START  in  1  begin sequencing; sampled only in IDLE
MAT_VALID  in  1  operand word present on fetch unit MAT_IN
INSTR_VALID  in  1  instruction word present on fetch unit INSTRDATA
INSTR  in  32  instruction latched by fetch unit
EXEC_DONE  in  1  execute stage finished current instruction
OUT_READY  in  1  result consumer accepts DATAOUT/RESULT
MATD_MUX  out  1  select MAT_IN into fetch unit
INS_MUX  out  1  select INSTRDATA into fetch unit
DOUT_MUX  out  1  drive result onto output
DONE  out  1  one-cycle pulse: fetch unit advances PC
EXEC_START  out  1  one-cycle pulse to execute stage
MAT_IDX  out  max(1,clog2(N))  operand word index being loaded
INSTR_CNT  out  clog2(REGN)  instructions retired since reset
BUSY  out  1  state not IDLE and not HALT
HALTED  out  1  sequencer stopped
ERR  out  1  watchdog timeout, sticky

Behaviour:
- Moore FSM; all outputs decoded from registered state/counters. No combinational input-to-output paths.
- Reset (async, RSTN=0): state IDLE; MAT_IDX=0, INSTR_CNT=0, ERR=0; all other outputs 0. Takes effect immediately, including mid-operation.
- IDLE: all strobes 0. START=1 -> LOAD next cycle.
- LOAD: MATD_MUX=1. Each cycle with MAT_VALID=1 accepts one word and increments MAT_IDX. Accepting with MAT_IDX==N-1 -> FETCH, MAT_IDX<=0. MAT_VALID=0 stalls in place.
- FETCH: INS_MUX=1. INSTR_VALID=1 -> ISSUE.
- ISSUE (1 cycle): INSTR==HALT_OP -> HALT with no EXEC_START. Otherwise -> EXEC.
- EXEC: EXEC_START=1 on the first EXEC cycle only. Wait for EXEC_DONE, which is sampled only in EXEC and ignored elsewhere. EXEC_DONE -> WB.
- WB: DOUT_MUX=1 held until OUT_READY=1 -> ADV.
- ADV (1 cycle): DONE=1; INSTR_CNT increments. If the old INSTR_CNT == REGN-1 -> HALT (end of memory, counter wraps to 0). Else -> LOAD.
- HALT: HALTED=1, all strobes 0. Sticky until RSTN.
- START outside IDLE is ignored.
- Latency: START to MATD_MUX=1 is 1 cycle. With zero-wait handshakes, minimum per-instruction period is N+5 cycles.

Optional Feature:
Macro WATCHDOG_EN.
- Defined: a counter clears on entry to EXEC and increments each cycle in EXEC or WB. When it reaches WDT_CYCLES before leaving WB, ERR<=1 (sticky) and state -> HALT; no DONE is issued.
- Undefined: no counter is built, ERR is tied 0, and EXEC/WB wait indefinitely.

Test Plan:
1. N=2: reset, START, MAT_VALID high 2 cycles, INSTR_VALID with INSTR=5, EXEC_DONE 3 cycles after EXEC_START, OUT_READY=1 -> MATD_MUX high exactly 2 cycles, one EXEC_START pulse, DOUT_MUX 1 cycle, one DONE pulse, INSTR_CNT=1, back in LOAD.
2. Stalls: MAT_VALID pattern 1,0,0,1; OUT_READY low 5 cycles -> MAT_IDX holds at 1 during gap; DOUT_MUX high 6 cycles; DONE only after OUT_READY.
3. INSTR=32'hFFFF_FFFF -> no EXEC_START, HALTED=1, BUSY=0; later START pulse changes nothing.
4. REGN=4, four instructions retired -> HALTED after the 4th DONE, INSTR_CNT=0.
5. RSTN asserted during EXEC -> outputs 0 without waiting for a clock edge; after release, START restarts cleanly from LOAD with MAT_IDX=0.
6. WATCHDOG_EN, WDT_CYCLES=8, EXEC_DONE held 0 -> ERR=1 and HALTED=1 after 8 cycles in EXEC, no DONE. Without the macro, the same stimulus leaves the block in EXEC with ERR=0.
